// File: rtl/nco_pkg.sv
// Shared types, widths and sanitising helpers for the NCO sweep sequencer.
package nco_pkg;

    localparam int FREQ_W    = 24;
    localparam int PHASE_W   = 7;
    localparam int PHASE_MAX = 100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Frequency words are forced into [1, fmax]; zero would stall the NCO.
    function automatic logic [FREQ_W-1:0] clamp_freq(
        input logic [FREQ_W-1:0] f,
        input int unsigned       fmax
    );
        logic [FREQ_W-1:0] r;
        if (f == '0) begin
            r = FREQ_W'(1);
        end else if ({8'd0, f} > fmax) begin
            r = fmax[FREQ_W-1:0];
        end else begin
            r = f;
        end
        return r;
    endfunction

    // Phase is a percentage; anything above PHASE_MAX is pinned to it.
    function automatic logic [PHASE_W-1:0] clamp_phase(input logic [PHASE_W-1:0] p);
        logic [PHASE_W-1:0] r;
        if (p > PHASE_W'(PHASE_MAX)) begin
            r = PHASE_W'(PHASE_MAX);
        end else begin
            r = p;
        end
        return r;
    endfunction

endpackage

// File: rtl/nco_freq_stepper.sv
// Combinational next-frequency calculation for a linear sweep. Steps towards
// f_stop and saturates on it, including when the add overflows or the
// subtract borrows. last_step flags the final frequency of the sweep.
module nco_freq_stepper
    import nco_pkg::*;
(
    input  logic [FREQ_W-1:0] cur,
    input  logic [FREQ_W-1:0] f_stop,
    input  logic [FREQ_W-1:0] step,
    input  logic              dir_up,
    output logic [FREQ_W-1:0] next_freq,
    output logic              last_step
);

    logic [FREQ_W:0] sum;
    logic [FREQ_W:0] diff;

    // One extra bit on both paths catches overflow and borrow.
    always_comb begin
        sum       = {1'b0, cur} + {1'b0, step};
        diff      = {1'b0, cur} - {1'b0, step};
        // A zero step would never reach f_stop, so treat it as a one-frequency sweep.
        last_step = (cur == f_stop) || (step == '0);
        next_freq = f_stop;
        if (dir_up) begin
            if (sum < {1'b0, f_stop}) begin
                next_freq = sum[FREQ_W-1:0];
            end
        end else begin
            if (!diff[FREQ_W] && (diff[FREQ_W-1:0] > f_stop)) begin
                next_freq = diff[FREQ_W-1:0];
            end
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Chirp sequencer driving NCO en / fre_chtr / pha_chtr. Captures a sanitised
// sweep descriptor on start, holds en low while the start phase loads, then
// steps the frequency every dwell period until f_stop (optionally repeating).
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY     = 50000000,
    parameter int unsigned FREQ_MAX          = CLK_FREQUENCY / 2,
    parameter int unsigned PHASE_LOAD_CYCLES = 2,
    parameter int unsigned DWELL_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FREQ_W-1:0]      cfg_f_start,
    input  logic [FREQ_W-1:0]      cfg_f_stop,
    input  logic [FREQ_W-1:0]      cfg_f_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [PHASE_W-1:0]     cfg_phase,
    input  logic                   cfg_repeat,
    output logic                   busy,
    output logic                   done,
    output logic                   nco_en,
    output logic [FREQ_W-1:0]      nco_fre_chtr,
    output logic [PHASE_W-1:0]     nco_pha_chtr
);

    localparam int LOAD_CNT_W = (PHASE_LOAD_CYCLES > 1) ? $clog2(PHASE_LOAD_CYCLES) : 1;
    localparam logic [LOAD_CNT_W-1:0] LOAD_LAST = LOAD_CNT_W'(PHASE_LOAD_CYCLES - 1);

    state_t state_reg, state_next;

    logic [FREQ_W-1:0]      sh_f_start_reg, sh_f_start_next;
    logic [FREQ_W-1:0]      sh_f_stop_reg,  sh_f_stop_next;
    logic [FREQ_W-1:0]      sh_step_reg,    sh_step_next;
    logic [DWELL_WIDTH-1:0] sh_dwell_reg,   sh_dwell_next;
    logic [PHASE_W-1:0]     sh_phase_reg,   sh_phase_next;
    logic                   sh_repeat_reg,  sh_repeat_next;
    logic                   sh_dir_up_reg,  sh_dir_up_next;

    logic [FREQ_W-1:0]      fre_reg,       fre_next;
    logic [PHASE_W-1:0]     pha_reg,       pha_next;
    logic [DWELL_WIDTH-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic [LOAD_CNT_W-1:0]  load_cnt_reg,  load_cnt_next;
    logic                   busy_reg,      busy_next;
    logic                   done_reg,      done_next;
    logic                   en_reg,        en_next;

    logic [FREQ_W-1:0]      cap_f_start;
    logic [FREQ_W-1:0]      cap_f_stop;
    logic [PHASE_W-1:0]     cap_phase;
    logic [DWELL_WIDTH-1:0] cap_dwell;

    logic                   start_ok;
    logic                   load_last;
    logic                   dwell_end;
    logic [FREQ_W-1:0]      step_freq;
    logic                   last_step;

    // Sanitised view of the configuration inputs, used only at capture.
    assign cap_f_start = clamp_freq(cfg_f_start, FREQ_MAX);
    assign cap_f_stop  = clamp_freq(cfg_f_stop, FREQ_MAX);
    assign cap_phase   = clamp_phase(cfg_phase);
    assign cap_dwell   = (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;

    assign start_ok  = (state_reg == IDLE) && start && !abort;
    assign load_last = (load_cnt_reg == LOAD_LAST);
    assign dwell_end = (dwell_cnt_reg == (sh_dwell_reg - DWELL_WIDTH'(1)));

    nco_freq_stepper u_stepper (
        .cur       (fre_reg),
        .f_stop    (sh_f_stop_reg),
        .step      (sh_step_reg),
        .dir_up    (sh_dir_up_reg),
        .next_freq (step_freq),
        .last_step (last_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort wins over every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_ok) state_next = LOAD;
            LOAD: begin
                if (abort)          state_next = IDLE;
                else if (load_last) state_next = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (dwell_end && last_step) begin
                    state_next = sh_repeat_reg ? LOAD : DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next values; flags decode the upcoming state so they register with it.
    always_comb begin
        sh_f_start_next = sh_f_start_reg;
        sh_f_stop_next  = sh_f_stop_reg;
        sh_step_next    = sh_step_reg;
        sh_dwell_next   = sh_dwell_reg;
        sh_phase_next   = sh_phase_reg;
        sh_repeat_next  = sh_repeat_reg;
        sh_dir_up_next  = sh_dir_up_reg;
        fre_next        = fre_reg;
        pha_next        = pha_reg;
        dwell_cnt_next  = dwell_cnt_reg;
        load_cnt_next   = load_cnt_reg;
        busy_next       = (state_next == LOAD) || (state_next == RUN);
        en_next         = (state_next == RUN);
        done_next       = (state_next == DONE);
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    sh_f_start_next = cap_f_start;
                    sh_f_stop_next  = cap_f_stop;
                    sh_step_next    = cfg_f_step;
                    sh_dwell_next   = cap_dwell;
                    sh_phase_next   = cap_phase;
                    sh_repeat_next  = cfg_repeat;
                    sh_dir_up_next  = (cap_f_stop >= cap_f_start);
                    fre_next        = cap_f_start;
                    pha_next        = cap_phase;
                    load_cnt_next   = '0;
                end
            end
            LOAD: begin
                if (!abort) begin
                    if (load_last) begin
                        dwell_cnt_next = '0;
                    end else begin
                        load_cnt_next = load_cnt_reg + LOAD_CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (!abort) begin
                    if (dwell_end) begin
                        dwell_cnt_next = '0;
                        if (!last_step) begin
                            fre_next = step_freq;
                        end else if (sh_repeat_reg) begin
                            fre_next      = sh_f_start_reg;
                            pha_next      = sh_phase_reg;
                            load_cnt_next = '0;
                        end
                    end else begin
                        dwell_cnt_next = dwell_cnt_reg + DWELL_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Shadow descriptor, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_f_start_reg <= FREQ_W'(1);
            sh_f_stop_reg  <= FREQ_W'(1);
            sh_step_reg    <= '0;
            sh_dwell_reg   <= DWELL_WIDTH'(1);
            sh_phase_reg   <= '0;
            sh_repeat_reg  <= 1'b0;
            sh_dir_up_reg  <= 1'b1;
            fre_reg        <= FREQ_W'(1);
            pha_reg        <= '0;
            dwell_cnt_reg  <= '0;
            load_cnt_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            en_reg         <= 1'b0;
        end else begin
            sh_f_start_reg <= sh_f_start_next;
            sh_f_stop_reg  <= sh_f_stop_next;
            sh_step_reg    <= sh_step_next;
            sh_dwell_reg   <= sh_dwell_next;
            sh_phase_reg   <= sh_phase_next;
            sh_repeat_reg  <= sh_repeat_next;
            sh_dir_up_reg  <= sh_dir_up_next;
            fre_reg        <= fre_next;
            pha_reg        <= pha_next;
            dwell_cnt_reg  <= dwell_cnt_next;
            load_cnt_reg   <= load_cnt_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            en_reg         <= en_next;
        end
    end

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign nco_en       = en_reg;
    assign nco_fre_chtr = fre_reg;
    assign nco_pha_chtr = pha_reg;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: a per-cycle expected-output queue
// built from the sweep rules, directed scenarios with literal expectations,
// then randomized start/abort/config traffic.
module tb_nco_sweep_ctrl;

    localparam int unsigned CLK_F = 20000000;
    localparam int unsigned FMAX  = CLK_F / 2;
    localparam int unsigned P     = 2;
    localparam int unsigned DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [23:0]   cfg_f_start, cfg_f_stop, cfg_f_step;
    logic [DW-1:0] cfg_dwell;
    logic [6:0]    cfg_phase;
    logic          cfg_repeat;
    logic          busy, done, nco_en;
    logic [23:0]   nco_fre_chtr;
    logic [6:0]    nco_pha_chtr;

    nco_sweep_ctrl #(
        .CLK_FREQUENCY     (CLK_F),
        .FREQ_MAX          (FMAX),
        .PHASE_LOAD_CYCLES (P),
        .DWELL_WIDTH       (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_f_start  (cfg_f_start),
        .cfg_f_stop   (cfg_f_stop),
        .cfg_f_step   (cfg_f_step),
        .cfg_dwell    (cfg_dwell),
        .cfg_phase    (cfg_phase),
        .cfg_repeat   (cfg_repeat),
        .busy         (busy),
        .done         (done),
        .nco_en       (nco_en),
        .nco_fre_chtr (nco_fre_chtr),
        .nco_pha_chtr (nco_pha_chtr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        en;
        logic [23:0] fre;
        logic [6:0]  pha;
    } obs_t;

    obs_t   q_exp[$];
    obs_t   obs[$];
    obs_t   m_last;
    longint m_fl[$];
    longint m_fs, m_stop, m_step;
    int     m_dwell, m_ph;
    bit     m_rep;
    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_sweeps = 0;

    function automatic obs_t mk(bit b, bit d, bit e, longint f, int p);
        obs_t r;
        r.busy = b; r.done = d; r.en = e;
        r.fre  = f[23:0];
        r.pha  = p[6:0];
        return r;
    endfunction

    function automatic obs_t dut_now();
        return mk(busy, done, nco_en, longint'(nco_fre_chtr), int'(nco_pha_chtr));
    endfunction

    task automatic check(string name, longint act, longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic check_vec(string name, obs_t a, obs_t e);
        n_checks++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s t=%0t got/required busy %b/%b done %b/%b en %b/%b fre %0d/%0d pha %0d/%0d",
                     name, $time, a.busy, e.busy, a.done, e.done, a.en, e.en,
                     a.fre, e.fre, a.pha, e.pha);
        end
    endtask

    // List of frequencies visited by one pass, straight from the sweep rules.
    function automatic void make_freq_list(longint fs, longint fstop, longint step);
        longint f = fs;
        bit up = (fstop >= fs);
        m_fl.delete();
        for (int guard = 0; guard < 100000; guard++) begin
            m_fl.push_back(f);
            if (f == fstop || step == 0) break;
            if (up) begin
                f = f + step;
                if (f > fstop) f = fstop;
            end else begin
                f = f - step;
                if (f < fstop) f = fstop;
            end
        end
    endfunction

    // Append one pass (load window + all dwells, plus done unless repeating).
    function automatic void build_pass();
        make_freq_list(m_fs, m_stop, m_step);
        for (int i = 0; i < int'(P); i++) q_exp.push_back(mk(1, 0, 0, m_fs, m_ph));
        foreach (m_fl[i])
            for (int d = 0; d < m_dwell; d++) q_exp.push_back(mk(1, 0, 1, m_fl[i], m_ph));
        if (!m_rep) q_exp.push_back(mk(0, 1, 0, m_fl[m_fl.size()-1], m_ph));
    endfunction

    function automatic longint san_f(longint f);
        if (f == 0) return 1;
        if (f > longint'(FMAX)) return longint'(FMAX);
        return f;
    endfunction

    task automatic model_reset();
        q_exp.delete();
        m_last = mk(0, 0, 0, 1, 0);
        m_rep  = 0;
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit was_idle = !m_last.busy && !m_last.done;
        if (was_idle) begin
            if (start && !abort) begin
                m_fs    = san_f(longint'(cfg_f_start));
                m_stop  = san_f(longint'(cfg_f_stop));
                m_step  = longint'(cfg_f_step);
                m_dwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
                m_ph    = (cfg_phase > 100) ? 100 : int'(cfg_phase);
                m_rep   = cfg_repeat;
                build_pass();
                n_sweeps++;
                $display("sweep %0d: start=%0d stop=%0d step=%0d dwell=%0d pha=%0d rep=%0d t=%0t",
                         n_sweeps, m_fs, m_stop, m_step, m_dwell, m_ph, m_rep, $time);
            end
        end else if (abort) begin
            q_exp.delete();
            m_last = mk(0, 0, 0, longint'(m_last.fre), int'(m_last.pha));
            return;
        end
        if (q_exp.size() > 0) begin
            m_last = q_exp.pop_front();
            if (q_exp.size() == 0 && m_last.busy && m_rep) build_pass();
        end else begin
            m_last = mk(0, 0, 0, longint'(m_last.fre), int'(m_last.pha));
        end
    endtask

    task automatic run_cycle();
        obs_t a;
        model_step();
        @(posedge clk);
        #1;
        a = dut_now();
        obs.push_back(a);
        check_vec("cycle", a, m_last);
    endtask

    task automatic run_n(int n);
        repeat (n) run_cycle();
    endtask

    task automatic set_cfg(longint fs, longint fstop, longint step, int dwell, int ph, bit rep);
        cfg_f_start = fs[23:0];
        cfg_f_stop  = fstop[23:0];
        cfg_f_step  = step[23:0];
        cfg_dwell   = DW'(dwell);
        cfg_phase   = ph[6:0];
        cfg_repeat  = rep;
    endtask

    task automatic begin_sweep();
        obs.delete();
        start = 1'b1;
        run_cycle();
        start = 1'b0;
    endtask

    task automatic rand_cfg();
        int mode = $urandom_range(0, 4);
        if (mode == 0) begin
            cfg_f_start = 24'($urandom_range(FMAX - 3000, FMAX + 4000));
            cfg_f_stop  = 24'($urandom_range(FMAX - 3000, FMAX + 4000));
        end else if (mode == 1) begin
            cfg_f_start = 24'($urandom_range(0, 20));
            cfg_f_stop  = 24'($urandom_range(0, 20));
        end else begin
            cfg_f_start = 24'($urandom_range(0, 5000));
            cfg_f_stop  = 24'($urandom_range(0, 5000));
        end
        case ($urandom_range(0, 9))
            0:       cfg_f_step = 24'd0;
            1:       cfg_f_step = 24'hFFFFFF;
            default: cfg_f_step = 24'($urandom_range(40, 700));
        endcase
        cfg_dwell  = DW'($urandom_range(0, 3));
        cfg_phase  = 7'($urandom_range(0, 127));
        cfg_repeat = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        int cnt, first_done, k;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_state", dut_now(), mk(0, 0, 0, 1, 0));
        rst_n = 1'b1;

        // Model pin: the up sweep must visit exactly 1000..1300 in steps of 100.
        make_freq_list(1000, 1300, 100);
        check("model_up_len", m_fl.size(), 4);
        check("model_up_last", m_fl[3], 1300);

        // Up sweep, with a stray start + new cfg while busy.
        set_cfg(1000, 1300, 100, 4, 25, 0);
        begin_sweep();
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) begin start = 1'b1; set_cfg(7, 9000, 3, 1, 90, 1); end
            run_cycle();
            start = 1'b0;
        end
        cnt = 0; first_done = -1;
        foreach (obs[i]) begin
            if (obs[i].busy) cnt++;
            if (obs[i].done && first_done < 0) first_done = i;
        end
        check("up_busy_cycles", cnt, 18);
        check("up_done_index", first_done, 18);
        check("up_load_en", obs[1].en, 0);
        check("up_load_pha", obs[0].pha, 25);
        check("up_f0", obs[2].fre, 1000);
        check("up_f1", obs[6].fre, 1100);
        check("up_f2", obs[10].fre, 1200);
        check("up_f3_end", obs[17].fre, 1300);
        check("up_idle_after", obs[19].busy, 0);

        // Down sweep with overshoot of the final step.
        set_cfg(5000, 4750, 100, 1, 0, 0);
        begin_sweep();
        run_n(8);
        cnt = 0;
        foreach (obs[i]) if (obs[i].en) cnt++;
        check("down_count", cnt, 4);
        check("down_f0", obs[2].fre, 5000);
        check("down_f1", obs[3].fre, 4900);
        check("down_f2", obs[4].fre, 4800);
        check("down_f3", obs[5].fre, 4750);
        check("down_done", obs[6].done, 1);

        // Sanitising: zero words, phase above 100, zero dwell.
        set_cfg(0, 0, 5, 0, 120, 0);
        begin_sweep();
        run_n(5);
        check("san_load_fre", obs[0].fre, 1);
        check("san_load_pha", obs[0].pha, 100);
        check("san_run_en", obs[2].en, 1);
        check("san_run_fre", obs[2].fre, 1);
        check("san_done", obs[3].done, 1);
        cnt = 0;
        foreach (obs[i]) if (obs[i].fre == 0) cnt++;
        check("san_fre_nonzero", cnt, 0);

        // Overflowing step saturates on f_stop = FREQ_MAX.
        set_cfg(FMAX - 5, FMAX, 24'hFFFFFF, 1, 0, 0);
        begin_sweep();
        run_n(6);
        check("ovf_f0", obs[2].fre, 9999995);
        check("ovf_f1", obs[3].fre, 10000000);
        check("ovf_done", obs[4].done, 1);

        // Repeat, then abort in RUN.
        set_cfg(10, 20, 10, 2, 50, 1);
        begin_sweep();
        run_n(14);
        check("rep_f_a", obs[2].fre, 10);
        check("rep_f_b", obs[5].fre, 20);
        check("rep_reload_en", obs[6].en, 0);
        check("rep_reload_busy", obs[7].busy, 1);
        check("rep_reload_fre", obs[7].fre, 10);
        check("rep_second_en", obs[8].en, 1);
        abort = 1'b1;
        run_cycle();
        abort = 1'b0;
        check("abort_busy", obs[15].busy, 0);
        check("abort_en", obs[15].en, 0);
        check("abort_fre_hold", obs[15].fre, 10);
        run_n(4);
        cnt = 0;
        for (int i = 15; i < obs.size(); i++) if (obs[i].done) cnt++;
        check("abort_no_done", cnt, 0);

        // start and abort together in IDLE.
        obs.delete();
        start = 1'b1; abort = 1'b1;
        run_cycle();
        start = 1'b0; abort = 1'b0;
        run_cycle();
        check("start_abort_idle0", obs[0].busy, 0);
        check("start_abort_idle1", obs[1].busy, 0);

        // Asynchronous reset in the middle of LOAD.
        set_cfg(3000, 3100, 50, 2, 60, 0);
        begin_sweep();
        #3;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset", dut_now(), mk(0, 0, 0, 1, 0));
        model_reset();
        @(posedge clk);
        #1;
        check_vec("reset_hold", dut_now(), mk(0, 0, 0, 1, 0));
        #1;
        rst_n = 1'b1;

        // Randomized traffic.
        for (k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 79) == 0);
            rand_cfg();
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencer that drives the configuration inputs of the NCO (en, fre_chtr, pha_chtr) to produce linear frequency sweeps (chirps). It sits between a host/register interface and the NCO. It captures a sweep descriptor, reloads the NCO start phase, steps the frequency control word every dwell period, and reports completion. It guarantees the NCO never sees fre_chtr = 0 or a phase word above 100.

## Interface
- CLK_FREQUENCY, 50000000, NCO clock in Hz
- FREQ_MAX, CLK_FREQUENCY/2, upper clamp for any frequency word
- PHASE_LOAD_CYCLES, 2, cycles en is held low to load the phase (≥1)
- DWELL_WIDTH, 16, width of dwell counter
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset (single clock, async assert, active low — fixed)
- start  in  1  request sweep; sampled only in IDLE
- abort  in  1  terminate sweep; priority over start
- cfg_f_start  in  24  first frequency word
- cfg_f_stop  in  24  last frequency word
- cfg_f_step  in  24  step magnitude
- cfg_dwell  in  DWELL_WIDTH  cycles per frequency (0 treated as 1)
- cfg_phase  in  7  start phase 0–100 %
- cfg_repeat  in  1  restart sweep endlessly until abort
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse at normal sweep end
- nco_en  out  1  to NCO en
- nco_fre_chtr  out  24  to NCO fre_chtr
- nco_pha_chtr  out  7  to NCO pha_chtr

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- IDLE → LOAD on start & !abort. Capture all cfg_* into shadow registers. Later cfg changes are ignored until the next start.
- Capture sanitising:
  - f_start and f_stop are clamped to [1, FREQ_MAX].
  - phase > 100 is clamped to 100.
  - dwell = 0 becomes 1.
  - Direction is up if f_stop ≥ f_start, else down.
- LOAD: nco_en = 0, nco_fre_chtr = f_start, nco_pha_chtr = phase. Held for PHASE_LOAD_CYCLES cycles, then → RUN.
- RUN: nco_en = 1; dwell counter counts dwell cycles per frequency. At the last dwell cycle:
  - If cur == f_stop: → LOAD (cfg_repeat captured = 1) or → DONE.
  - Else cur ← next. Up: next = min(cur + step, f_stop), computed 25-bit, so overflow saturates to f_stop. Down: next = max(cur − step, f_stop), with borrow saturating to f_stop.
- step = 0, or f_start == f_stop: a single dwell at f_start, then end.
- DONE: done = 1, nco_en = 0 for one cycle, then → IDLE.
- abort in LOAD/RUN/DONE: next state IDLE, nco_en = 0, no done pulse, nco_fre_chtr/nco_pha_chtr hold their last value.
- start while not IDLE is ignored.
- IDLE: nco_en = 0; frequency and phase words hold their last value.

## Timing
- Reset values: state IDLE, busy 0, done 0, nco_en 0, nco_fre_chtr 24'd1, nco_pha_chtr 0, dwell counter 0.
- start sampled high at edge k: from edge k, busy = 1, nco_en = 0, words = f_start/phase.
- First nco_en = 1 at edge k + PHASE_LOAD_CYCLES.
- Each frequency is presented for exactly dwell cycles with nco_en = 1. The new nco_fre_chtr takes effect on the same edge the previous dwell ends; there is no gap.
- Sweep of N frequencies: busy high for PHASE_LOAD_CYCLES + N·dwell cycles, then done for 1 cycle, then IDLE. A new start is accepted in the cycle after done.
- Repeat: the final dwell is followed directly by LOAD (nco_en low PHASE_LOAD_CYCLES cycles); busy stays 1.
- abort is effective at the next edge.
- Reset mid-sweep returns all outputs to reset values immediately (async).

## Structure
- Package nco_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE)
  - FREQ_W = 24, PHASE_W = 7, PHASE_MAX = 100
  - clamp functions for frequency and phase
- Sub-module nco_freq_stepper: combinational next-frequency calculation (direction, saturation at f_stop, last-step flag). The FSM, dwell counter and load counter stay in nco_sweep_ctrl.
- Top level instantiates nco_sweep_ctrl feeding the NCO.

## Test plan
- Up sweep: f_start = 1000, f_stop = 1300, step = 100, dwell = 4, phase = 25, P = 2.
  - → nco_en low 2 cycles with pha 25.
  - → 1000/1100/1200/1300 each 4 cycles.
  - → done pulse at cycle 18 after start; busy high 18 cycles.
- Down with overshoot: 5000 → 4750, step 100, dwell 1 → 5000, 4900, 4800, 4750, done.
- Sanitising: f_start = 0, f_stop = 0, phase = 120, dwell = 0 → single cycle at fre 1, pha 100, done; fre_chtr never 0.
- Repeat: 10 → 20 step 10 dwell 2 repeat = 1 → sequence 10, 10, 20, 20, then en low 2 cycles, repeating. Abort mid-RUN → IDLE next edge, no done, en 0.
- Overflow: f_start = FREQ_MAX − 5, step = 2^24 − 1, f_stop = FREQ_MAX → second frequency equals FREQ_MAX exactly.
- start during busy ignored; start & abort together in IDLE → stays IDLE; async reset mid-LOAD → reset values without waiting for clk.
